// File: rtl/mem_stage_access.sv
// MIPS memory-stage access unit: drives a req/ack data-memory port for loads and
// stores, aligns sub-word data, stalls upstream while busy and registers MEM/WB fields.
module mem_stage_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  writeRegister,
    input  logic [31:0] writeData,
    input  logic [31:0] aluOut,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [3:0]  memWrite,
    input  logic [1:0]  memReadWidth,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    output logic        stall,
    output logic [31:0] readDataOut,
    output logic [31:0] aluOutOut,
    output logic [4:0]  writeRegisterOut,
    output logic        regWriteOut,
    output logic        memToRegOut,
    output logic        error
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    width_q, width_d;

    logic [31:0]   rdata_out_q, rdata_out_d;
    logic [31:0]   alu_out_q, alu_out_d;
    logic [4:0]    wreg_q, wreg_d;
    logic          regw_q, regw_d;
    logic          m2r_q, m2r_d;
    logic          err_q, err_d;

    logic          is_store;
    logic          mem_op;
    logic          misaligned;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic          bubble;
    logic          capture_load;

    // Decode the access and detect misalignment against the access size.
    always_comb begin
        is_store   = (memWrite != 4'b0000);
        mem_op     = memToReg | is_store;
        misaligned = 1'b0;
        if (is_store) begin
            case (memWrite)
                4'b1111: misaligned = (aluOut[1:0] != 2'b00);
                4'b0011: misaligned = aluOut[0];
                default: misaligned = 1'b0;
            endcase
        end else if (memToReg) begin
            case (memReadWidth)
                2'b00:   misaligned = (aluOut[1:0] != 2'b00);
                2'b01:   misaligned = aluOut[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    // Store lane placement; unrecognised nonzero codes act as a raw byte mask.
    always_comb begin
        case (memWrite)
            4'b0001: begin
                be_new    = 4'b0001 << aluOut[1:0];
                wdata_new = {4{writeData[7:0]}};
            end
            4'b0011: begin
                be_new    = 4'b0011 << aluOut[1:0];
                wdata_new = {2{writeData[15:0]}};
            end
            default: begin
                be_new    = memWrite;
                wdata_new = writeData;
            end
        endcase
        if (!is_store) begin
            be_new = 4'b1111;
        end
    end

    // Load extraction uses the lane offset and width captured at request time.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = memRdata[7:0];
            2'd1:    byte_sel = memRdata[15:8];
            2'd2:    byte_sel = memRdata[23:16];
            default: byte_sel = memRdata[31:24];
        endcase
        half_sel = off_q[1] ? memRdata[31:16] : memRdata[15:0];
        case (width_q)
            2'b00:   load_data = memRdata;
            2'b01:   load_data = {{16{half_sel[15]}}, half_sel};
            2'b10:   load_data = {{24{byte_sel[7]}}, byte_sel};
            default: load_data = {24'b0, byte_sel};
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        width_d      = width_q;
        err_d        = 1'b0;
        stall        = 1'b0;
        bubble       = 1'b0;
        capture_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op && !misaligned) begin
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {aluOut[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    off_d   = aluOut[1:0];
                    width_d = memReadWidth;
                    cnt_d   = '0;
                end else if (mem_op) begin
                    err_d  = 1'b1;
                    bubble = 1'b1;
                end
            end
            ST_BUSY: begin
                if (memAck) begin
                    state_d      = ST_IDLE;
                    req_d        = 1'b0;
                    capture_load = !we_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abandon the access: release the pipeline and retire a bubble.
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    bubble  = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdata_out_d = rdata_out_q;
        alu_out_d   = alu_out_q;
        wreg_d      = wreg_q;
        regw_d      = 1'b0;
        m2r_d       = 1'b0;
        if (!stall) begin
            alu_out_d = aluOut;
            wreg_d    = writeRegister;
            regw_d    = regWrite & !bubble;
            m2r_d     = memToReg & !bubble;
            if (capture_load) begin
                rdata_out_d = load_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            off_q       <= '0;
            width_q     <= '0;
            rdata_out_q <= '0;
            alu_out_q   <= '0;
            wreg_q      <= '0;
            regw_q      <= 1'b0;
            m2r_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            width_q     <= width_d;
            rdata_out_q <= rdata_out_d;
            alu_out_q   <= alu_out_d;
            wreg_q      <= wreg_d;
            regw_q      <= regw_d;
            m2r_q       <= m2r_d;
            err_q       <= err_d;
        end
    end

    assign memReq           = req_q;
    assign memWe            = we_q;
    assign memAddr          = addr_q;
    assign memBe            = be_q;
    assign memWdata         = wdata_q;
    assign readDataOut      = rdata_out_q;
    assign aluOutOut        = alu_out_q;
    assign writeRegisterOut = wreg_q;
    assign regWriteOut      = regw_q;
    assign memToRegOut      = m2r_q;
    assign error            = err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access: passthrough, loads, stores,
// misalignment, timeout and mid-access reset.
module tb_mem_stage_access;

    localparam int TIMEOUT = 16;

    logic        clock;
    logic        reset;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] aluOut;
    logic        regWrite;
    logic        memToReg;
    logic [3:0]  memWrite;
    logic [1:0]  memReadWidth;
    logic        memAck;
    logic [31:0] memRdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        stall;
    logic [31:0] readDataOut;
    logic [31:0] aluOutOut;
    logic [4:0]  writeRegisterOut;
    logic        regWriteOut;
    logic        memToRegOut;
    logic        error;

    int checks;
    int failures;

    mem_stage_access #(.TIMEOUT(TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .writeRegister    (writeRegister),
        .writeData        (writeData),
        .aluOut           (aluOut),
        .regWrite         (regWrite),
        .memToReg         (memToReg),
        .memWrite         (memWrite),
        .memReadWidth     (memReadWidth),
        .memAck           (memAck),
        .memRdata         (memRdata),
        .memReq           (memReq),
        .memWe            (memWe),
        .memAddr          (memAddr),
        .memBe            (memBe),
        .memWdata         (memWdata),
        .stall            (stall),
        .readDataOut      (readDataOut),
        .aluOutOut        (aluOutOut),
        .writeRegisterOut (writeRegisterOut),
        .regWriteOut      (regWriteOut),
        .memToRegOut      (memToRegOut),
        .error            (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        writeRegister = '0;
        writeData     = '0;
        aluOut        = '0;
        regWrite      = 1'b0;
        memToReg      = 1'b0;
        memWrite      = '0;
        memReadWidth  = '0;
    endtask

    // Runs the presented memory op to completion, acking k cycles after memReq rises.
    task automatic run_access(input int k, input logic [31:0] rdata,
                              output int stall_cycles, output int req_cycles);
        int  hi;
        bit  done;
        hi           = 0;
        done         = 1'b0;
        stall_cycles = 0;
        req_cycles   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (memReq) begin
                if (hi == k) begin
                    memAck   = 1'b1;
                    memRdata = rdata;
                    done     = 1'b1;
                end
                hi++;
                req_cycles++;
            end
            #1;
            if (stall) stall_cycles++;
            @(posedge clock);
            #1;
            memAck = 1'b0;
        end
        check("access_completed", 32'(done), 32'd1);
    endtask

    int sc;
    int rc;
    int tcnt;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        memAck   = 1'b0;
        memRdata = '0;
        nop();
        tick();
        tick();

        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_aluOutOut", aluOutOut, 32'd0);
        check("rst_readDataOut", readDataOut, 32'd0);
        check("rst_regWriteOut", 32'(regWriteOut), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();

        // ALU passthrough, three back-to-back results
        for (int i = 0; i < 3; i++) begin
            aluOut        = 32'h5 + 32'(i);
            regWrite      = 1'b1;
            writeRegister = 5'd3;
            #1;
            check("alu_stall", 32'(stall), 32'd0);
            tick();
            check("alu_aluOutOut", aluOutOut, 32'h5 + 32'(i));
            check("alu_regWriteOut", 32'(regWriteOut), 32'd1);
            check("alu_memReq", 32'(memReq), 32'd0);
        end
        check("alu_wreg", 32'(writeRegisterOut), 32'd3);
        nop();
        tick();

        // Word load, ack 3 cycles after request
        aluOut        = 32'h100;
        memToReg      = 1'b1;
        regWrite      = 1'b1;
        writeRegister = 5'd8;
        memReadWidth  = 2'b00;
        run_access(3, 32'hDEADBEEF, sc, rc);
        check("lw_stall_cycles", 32'(sc), 32'd4);
        check("lw_req_cycles", 32'(rc), 32'd4);
        check("lw_readDataOut", readDataOut, 32'hDEADBEEF);
        check("lw_memToRegOut", 32'(memToRegOut), 32'd1);
        check("lw_regWriteOut", 32'(regWriteOut), 32'd1);
        check("lw_wreg", 32'(writeRegisterOut), 32'd8);
        check("lw_memAddr", memAddr, 32'h100);
        check("lw_memBe", 32'(memBe), 32'hF);
        check("lw_memWe", 32'(memWe), 32'd0);
        check("lw_memReq_low", 32'(memReq), 32'd0);
        nop();
        tick();

        // Signed byte load, lane 3, immediate ack
        aluOut       = 32'h203;
        memToReg     = 1'b1;
        regWrite     = 1'b1;
        memReadWidth = 2'b10;
        run_access(0, 32'h80123456, sc, rc);
        check("lb_stall_cycles", 32'(sc), 32'd1);
        check("lb_req_cycles", 32'(rc), 32'd1);
        check("lb_readDataOut", readDataOut, 32'hFFFFFF80);
        check("lb_memAddr", memAddr, 32'h200);
        nop();
        tick();

        // Unsigned byte load, same lane
        aluOut       = 32'h203;
        memToReg     = 1'b1;
        regWrite     = 1'b1;
        memReadWidth = 2'b11;
        run_access(0, 32'h80123456, sc, rc);
        check("lbu_readDataOut", readDataOut, 32'h00000080);
        nop();
        tick();

        // Half store at upper lane
        aluOut    = 32'h102;
        writeData = 32'h1234ABCD;
        memWrite  = 4'b0011;
        run_access(1, 32'h0, sc, rc);
        check("sh_stall_cycles", 32'(sc), 32'd2);
        check("sh_memWe", 32'(memWe), 32'd1);
        check("sh_memBe", 32'(memBe), 32'hC);
        check("sh_memWdata", memWdata, 32'hABCDABCD);
        check("sh_memAddr", memAddr, 32'h100);
        check("sh_regWriteOut", 32'(regWriteOut), 32'd0);
        check("sh_readData_hold", readDataOut, 32'h00000080);
        nop();
        tick();

        // Misaligned word load
        aluOut        = 32'h101;
        memToReg      = 1'b1;
        regWrite      = 1'b1;
        writeRegister = 5'd9;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        check("mis_error", 32'(error), 32'd1);
        check("mis_memReq", 32'(memReq), 32'd0);
        check("mis_regWriteOut", 32'(regWriteOut), 32'd0);
        check("mis_memToRegOut", 32'(memToRegOut), 32'd0);
        nop();
        tick();
        check("mis_error_pulse", 32'(error), 32'd0);

        // Timeout: never ack
        aluOut        = 32'h40;
        memToReg      = 1'b1;
        regWrite      = 1'b1;
        memReadWidth  = 2'b00;
        tcnt = 0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (!stall) break;
            tcnt++;
            tick();
        end
        check("to_stall_cycles", 32'(tcnt), 32'(TIMEOUT));
        check("to_final_memReq", 32'(memReq), 32'd1);
        tick();
        check("to_error", 32'(error), 32'd1);
        check("to_memReq", 32'(memReq), 32'd0);
        check("to_regWriteOut", 32'(regWriteOut), 32'd0);
        check("to_memToRegOut", 32'(memToRegOut), 32'd0);
        nop();
        tick();
        check("to_error_pulse", 32'(error), 32'd0);

        // Reset asserted during BUSY
        aluOut   = 32'h80;
        memToReg = 1'b1;
        regWrite = 1'b1;
        tick();
        check("rb_memReq", 32'(memReq), 32'd1);
        tick();
        reset = 1'b1;
        nop();
        #1;
        check("rb_memReq_low", 32'(memReq), 32'd0);
        check("rb_memAddr", memAddr, 32'd0);
        check("rb_memBe", 32'(memBe), 32'd0);
        check("rb_readDataOut", readDataOut, 32'd0);
        check("rb_aluOutOut", aluOutOut, 32'd0);
        check("rb_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Ack while IDLE is ignored; a plain op passes straight through
        memAck   = 1'b1;
        memRdata = 32'h12345678;
        aluOut   = 32'h77;
        regWrite = 1'b1;
        #1;
        check("idle_ack_stall", 32'(stall), 32'd0);
        tick();
        memAck = 1'b0;
        check("idle_ack_memReq", 32'(memReq), 32'd0);
        check("idle_ack_readData", readDataOut, 32'd0);
        check("idle_ack_aluOutOut", aluOutOut, 32'h77);
        nop();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
